// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IC pipeline: load-use, taken-branch squash and
// data-memory wait handling, with saturating event counters and a sticky memory-timeout flag.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_en,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int              WC_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_cnt_nxt;
  logic             r_mem_error;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  logic w_lu;
  logic w_mw;
  logic w_timeout;
  logic w_freeze;
  logic w_branch;

  assign w_lu = hazard_en & id_ex_mem_read & (id_ex_rd != 5'd0) &
                ((id_ex_rd == if_id_rs1) | (id_ex_rd == if_id_rs2));
  assign w_mw = mem_req & ~mem_ready;

  // The last permitted wait cycle releases the pipeline instead of freezing it again.
  assign w_timeout = (r_state == ST_MEM_WAIT) & w_mw & (r_wait_cnt == WAIT_LAST);
  assign w_freeze  = w_mw & ~w_timeout;
  assign w_branch  = ~rst & ~w_freeze & ex_branch_taken;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (rst) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_mem_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_timeout) begin
        r_mem_error <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- next-state logic
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a target unassigned,
    // which would otherwise infer a latch.
    w_state_nxt    = ST_RUN;
    w_wait_cnt_nxt = '0;
    unique case (r_state)
      ST_RUN: begin
        if (w_freeze) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WC_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (w_freeze) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- output decode
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    stall        = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
    end else if (w_freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      stall        = 1'b1;
    end else if (ex_branch_taken) begin
      // The squashed ID instruction makes any load-use match irrelevant.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (w_lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      stall       = 1'b1;
    end
  end

  // ---------------------------------------------------------------- event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_branch && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign mem_error    = r_mem_error;
  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: directed scenarios then biased random traffic,
// checked against a behavioural pipeline-control model.
module tb_hazard_stall_ctrl;

  localparam int TO    = 4;
  localparam int CW    = 5;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          hazard_en;
  logic [4:0]    if_id_rs1, if_id_rs2, id_ex_rd;
  logic          id_ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic          if_id_flush, id_ex_flush, stall, mem_error;
  logic [CW-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .hazard_en(hazard_en),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_mem_read(id_ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .stall(stall), .mem_error(mem_error),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  typedef struct {
    logic [3:0] wr;     // {pc, if_id, id_ex, ex_mem}
    logic [1:0] fl;     // {if_id_flush, id_ex_flush}
    logic       stall;
    logic       err;
    int         stalls;
    int         flushes;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: count of consecutive frozen cycles in the current memory wait.
  int   m_waited  = 0;
  logic m_err     = 1'b0;
  int   m_stalls  = 0;
  int   m_flushes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the response, advance the model, then pass the edge.
  task automatic step(input logic r, input logic he, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic ld, input logic br,
                      input logic mq, input logic mrdy);
    exp_t e;
    bit   lu, mw, frz;
    rst = r; hazard_en = he; if_id_rs1 = rs1; if_id_rs2 = rs2; id_ex_rd = rd;
    id_ex_mem_read = ld; ex_branch_taken = br; mem_req = mq; mem_ready = mrdy;

    lu  = he && ld && (rd != 0) && (rd == rs1 || rd == rs2);
    mw  = mq && !mrdy;
    frz = mw && (m_waited < TO - 1);
    e.err = m_err; e.stalls = m_stalls; e.flushes = m_flushes;
    if (r)        begin e.wr = 4'b0000; e.fl = 2'b11; e.stall = 1'b0; end
    else if (frz) begin e.wr = 4'b0000; e.fl = 2'b00; e.stall = 1'b1; end
    else if (br)  begin e.wr = 4'b1111; e.fl = 2'b11; e.stall = 1'b0; end
    else if (lu)  begin e.wr = 4'b0011; e.fl = 2'b01; e.stall = 1'b1; end
    else          begin e.wr = 4'b1111; e.fl = 2'b00; e.stall = 1'b0; end
    q.push_back(e);

    if (r) begin
      m_waited = 0; m_err = 1'b0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!mw)          m_waited = 0;
      else if (frz)     m_waited++;
      else begin        m_waited = 0; m_err = 1'b1; end
      if (e.stall && m_stalls < CMAX) m_stalls++;
      if (!frz && br && m_flushes < CMAX) m_flushes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents one response, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pc_write",     32'(pc_write),     32'(e.wr[3]));
        check("if_id_write",  32'(if_id_write),  32'(e.wr[2]));
        check("id_ex_write",  32'(id_ex_write),  32'(e.wr[1]));
        check("ex_mem_write", 32'(ex_mem_write), 32'(e.wr[0]));
        check("if_id_flush",  32'(if_id_flush),  32'(e.fl[1]));
        check("id_ex_flush",  32'(id_ex_flush),  32'(e.fl[0]));
        check("stall",        32'(stall),        32'(e.stall));
        check("mem_error",    32'(mem_error),    32'(e.err));
        check("stall_cycles", 32'(stall_cycles), 32'(e.stalls));
        check("flush_count",  32'(flush_count),  32'(e.flushes));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hazard_en = 1'b1; if_id_rs1 = '0; if_id_rs2 = '0; id_ex_rd = '0;
    id_ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);          // reset pattern, counters zero
    idle(2);
    step(0, 1, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0);          // load-use on rs2
    idle(1);
    step(0, 0, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0);          // same with detection disabled
    step(0, 1, 5'd0, 5'd7, 5'd0, 1, 0, 0, 0);          // rd = x0 never stalls
    step(0, 1, 5'd9, 5'd2, 5'd9, 1, 1, 0, 0);          // branch wins over load-use
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);
    step(0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 1);          // release after 3 frozen cycles
    idle(1);
    for (int i = 0; i < 4; i++) step(0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);  // timeout on 4th
    idle(2);                                           // mem_error stays set
    step(0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);          // enter wait
    step(1, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);          // reset on 2nd wait cycle
    idle(2);
    step(0, 1, 5'd1, 5'd2, 5'd3, 0, 0, 1, 0);          // wait then mem_req drops -> release
    step(0, 1, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0);
    idle(1);

    // Biased random traffic; a long reset-free stretch drives counters into saturation.
    for (int i = 0; i < 700; i++) begin
      logic r;
      r = (i > 400) && ($urandom_range(0, 59) == 0);
      step(r, ($urandom_range(0, 7) != 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end
    idle(2);
    @(negedge clk);
    check("queue_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
